// File: rtl/noc_flit_pkg.sv
// Shared NoC flit definitions: control-bit positions, assembler states, flit width.
package noc_flit_pkg;

  // Control-bit offsets measured down from the flit MSB (bit index = W - OFS).
  localparam int FLIT_VALID_OFS = 1;
  localparam int FLIT_HEAD_OFS  = 2;
  localparam int FLIT_TAIL_OFS  = 3;

  typedef enum logic [2:0] {
    WAIT_HEAD,
    WAIT_B1,
    WAIT_B2,
    WAIT_TAIL,
    FULL
  } asm_state_e;

  function automatic int flit_w(input int width_pkt);
    return width_pkt / 4;
  endfunction

endpackage

// File: rtl/flit_assembler_4.sv
// Reassembles head/body1/body2/tail flits into one packet word with valid/ready
// output; malformed sequences are discarded, pulsed on o_error and counted.
module flit_assembler_4
  import noc_flit_pkg::*;
#(
  parameter int WIDTH_PKT        = 36,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 4,
  parameter int ERR_CNT_WIDTH    = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [flit_w(WIDTH_PKT)-1:0]    i_flit_in,
  input  logic                            i_valid_in,
  output logic                            i_ready_out,
  output logic [WIDTH_PKT-1:0]            o_packet_out,
  output logic                            o_valid_out,
  input  logic                            o_ready_in,
  output logic                            o_error,
  output logic [ERR_CNT_WIDTH-1:0]        o_err_count
);

  localparam int W = flit_w(WIDTH_PKT);

  if ((WIDTH_PKT % 4) != 0 || W < 3 + VC_ADDRESS_WIDTH + ADDRESS_WIDTH) begin : g_bad_cfg
    $error("flit_assembler_4: WIDTH_PKT too small or not a multiple of 4");
  end

  asm_state_e               state_q;
  logic [WIDTH_PKT-1:0]     pkt_q;
  logic                     valid_q, err_q;
  logic [ERR_CNT_WIDTH-1:0] cnt_q;

  logic flit_real, hd, tl, err_ev;

  // Combinational on o_ready_in so a new head can enter the cycle FULL drains.
  assign i_ready_out = (state_q != FULL) || o_ready_in;
  assign flit_real   = i_valid_in && i_ready_out && i_flit_in[W-FLIT_VALID_OFS];
  assign hd          = i_flit_in[W-FLIT_HEAD_OFS];
  assign tl          = i_flit_in[W-FLIT_TAIL_OFS];

  always_comb begin
    err_ev = 1'b0;
    if (flit_real) begin
      case (state_q)
        WAIT_HEAD, FULL:  err_ev = !(hd && !tl);
        WAIT_B1, WAIT_B2: err_ev = hd || tl;
        WAIT_TAIL:        err_ev = hd || !tl;
        default:          err_ev = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_HEAD;
      pkt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      err_q <= err_ev;
      if (err_ev && cnt_q != '1) cnt_q <= cnt_q + ERR_CNT_WIDTH'(1);

      if (state_q == FULL && o_ready_in) begin
        valid_q <= 1'b0;
        state_q <= WAIT_HEAD;
      end

      if (flit_real) begin
        case (state_q)
          WAIT_HEAD, FULL: begin
            if (hd && !tl) begin
              pkt_q[3*W +: W] <= i_flit_in;
              state_q         <= WAIT_B1;
            end
          end
          WAIT_B1, WAIT_B2: begin
            if (hd) begin
              pkt_q[3*W +: W] <= i_flit_in;
              state_q         <= WAIT_B1;
            end else if (tl) begin
              state_q <= WAIT_HEAD;
            end else if (state_q == WAIT_B1) begin
              pkt_q[2*W +: W] <= i_flit_in;
              state_q         <= WAIT_B2;
            end else begin
              pkt_q[1*W +: W] <= i_flit_in;
              state_q         <= WAIT_TAIL;
            end
          end
          WAIT_TAIL: begin
            if (hd) begin
              pkt_q[3*W +: W] <= i_flit_in;
              state_q         <= WAIT_B1;
            end else if (!tl) begin
              state_q <= WAIT_HEAD;
            end else begin
              pkt_q[0 +: W] <= i_flit_in;
              state_q       <= FULL;
              valid_q       <= 1'b1;
            end
          end
          default: state_q <= WAIT_HEAD;
        endcase
      end
    end
  end

  assign o_packet_out = pkt_q;
  assign o_valid_out  = valid_q;
  assign o_error      = err_q;
  assign o_err_count  = cnt_q;

endmodule

// File: tb/tb_flit_assembler_4.sv
// Directed bench for flit_assembler_4 with default parameters (9-bit flits).
module tb_flit_assembler_4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  i_flit_in;
  logic        i_valid_in;
  logic        i_ready_out;
  logic [35:0] o_packet_out;
  logic        o_valid_out;
  logic        o_ready_in;
  logic        o_error;
  logic [7:0]  o_err_count;

  int total = 0;
  int bad   = 0;

  localparam logic [8:0]  HEAD = 9'h187, B1 = 9'h115, B2 = 9'h10A, TAIL = 9'h15F;
  localparam logic [35:0] PKT  = 36'hC3C56155F;

  flit_assembler_4 dut (
    .clk(clk), .rst_n(rst_n),
    .i_flit_in(i_flit_in), .i_valid_in(i_valid_in), .i_ready_out(i_ready_out),
    .o_packet_out(o_packet_out), .o_valid_out(o_valid_out), .o_ready_in(o_ready_in),
    .o_error(o_error), .o_err_count(o_err_count)
  );

  always #5 clk = ~clk;

  // Drive at a negedge, clock once, return at the following negedge.
  task automatic cyc(input logic [8:0] f, input logic v, input logic r);
    i_flit_in  = f;
    i_valid_in = v;
    o_ready_in = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_consume();
    cyc(9'h000, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_flit_in = '0; i_valid_in = 1'b0; o_ready_in = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (o_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", o_valid_out); end
    total++; if (o_packet_out !== 36'h0) begin bad++; $display("FAIL reset_pkt got=%h exp=0", o_packet_out); end
    total++; if (o_error !== 1'b0 || o_err_count !== 8'h00) begin bad++; $display("FAIL reset_err got=%0b/%h exp=0/00", o_error, o_err_count); end
    total++; if (i_ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", i_ready_out); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_nominal();
    cyc(HEAD, 1, 1);
    cyc(B1, 1, 1);
    cyc(B2, 1, 1);
    total++; if (o_valid_out !== 1'b0) begin bad++; $display("FAIL nom_early_valid got=%0b exp=0", o_valid_out); end
    cyc(TAIL, 1, 1);
    total++; if (o_valid_out !== 1'b1) begin bad++; $display("FAIL nom_valid got=%0b exp=1", o_valid_out); end
    total++; if (o_packet_out !== PKT) begin bad++; $display("FAIL nom_pkt got=%h exp=%h", o_packet_out, PKT); end
    total++; if (o_error !== 1'b0) begin bad++; $display("FAIL nom_err got=%0b exp=0", o_error); end
    idle_consume();
    total++; if (o_valid_out !== 1'b0) begin bad++; $display("FAIL nom_one_cycle got=%0b exp=0", o_valid_out); end
  endtask

  task automatic test_back_to_back();
    logic [8:0] seq [8];
    seq = '{HEAD, B1, B2, TAIL, HEAD, B1, B2, TAIL};
    for (int k = 0; k < 8; k++) begin
      i_flit_in = seq[k]; i_valid_in = 1'b1; o_ready_in = 1'b1;
      #1;
      total++; if (i_ready_out !== 1'b1) begin bad++; $display("FAIL b2b_ready k=%0d got=%0b exp=1", k, i_ready_out); end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (o_valid_out !== ((k == 3 || k == 7) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL b2b_valid k=%0d got=%0b", k, o_valid_out);
      end
    end
    total++; if (o_packet_out !== PKT) begin bad++; $display("FAIL b2b_pkt got=%h exp=%h", o_packet_out, PKT); end
    idle_consume();
  endtask

  task automatic test_stall();
    cyc(HEAD, 1, 1); cyc(B1, 1, 1); cyc(B2, 1, 1); cyc(TAIL, 1, 1);
    for (int k = 0; k < 5; k++) begin
      i_flit_in = HEAD; i_valid_in = 1'b1; o_ready_in = 1'b0;
      #1;
      total++; if (i_ready_out !== 1'b0) begin bad++; $display("FAIL stall_ready k=%0d got=%0b exp=0", k, i_ready_out); end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (o_valid_out !== 1'b1 || o_packet_out !== PKT) begin
        bad++; $display("FAIL stall_hold k=%0d got=%0b/%h exp=1/%h", k, o_valid_out, o_packet_out, PKT);
      end
    end
    cyc(HEAD, 1, 1);
    total++; if (o_valid_out !== 1'b0) begin bad++; $display("FAIL stall_release got=%0b exp=0", o_valid_out); end
    cyc(B1, 1, 1); cyc(B2, 1, 1); cyc(TAIL, 1, 1);
    total++; if (o_valid_out !== 1'b1 || o_packet_out !== PKT) begin bad++; $display("FAIL stall_next got=%0b/%h exp=1/%h", o_valid_out, o_packet_out, PKT); end
    total++; if (o_err_count !== 8'h00) begin bad++; $display("FAIL stall_errcnt got=%h exp=00", o_err_count); end
    idle_consume();
  endtask

  task automatic test_early_head();
    cyc(HEAD, 1, 1); cyc(B1, 1, 1); cyc(HEAD, 1, 1);
    total++; if (o_error !== 1'b1 || o_err_count !== 8'h01) begin bad++; $display("FAIL early_err got=%0b/%h exp=1/01", o_error, o_err_count); end
    cyc(B1, 1, 1);
    total++; if (o_error !== 1'b0) begin bad++; $display("FAIL early_pulse got=%0b exp=0", o_error); end
    cyc(B2, 1, 1); cyc(TAIL, 1, 1);
    total++; if (o_valid_out !== 1'b1 || o_packet_out !== PKT) begin bad++; $display("FAIL early_pkt got=%0b/%h exp=1/%h", o_valid_out, o_packet_out, PKT); end
    idle_consume();
  endtask

  task automatic test_bubbles_orphans();
    cyc(HEAD, 1, 1); cyc(9'h000, 1, 1); cyc(B1, 1, 1); cyc(9'h000, 1, 1);
    cyc(B2, 1, 1); cyc(TAIL, 1, 1);
    total++; if (o_valid_out !== 1'b1 || o_packet_out !== PKT) begin bad++; $display("FAIL bubble_pkt got=%0b/%h exp=1/%h", o_valid_out, o_packet_out, PKT); end
    total++; if (o_err_count !== 8'h01) begin bad++; $display("FAIL bubble_errcnt got=%h exp=01", o_err_count); end
    idle_consume();
    cyc(B1, 1, 1);
    total++; if (o_error !== 1'b1 || o_err_count !== 8'h02) begin bad++; $display("FAIL orphan_err got=%0b/%h exp=1/02", o_error, o_err_count); end
    for (int k = 0; k < 299; k++) cyc(B1, 1, 1);
    total++; if (o_err_count !== 8'hFF) begin bad++; $display("FAIL sat_cnt got=%h exp=FF", o_err_count); end
    total++; if (o_valid_out !== 1'b0) begin bad++; $display("FAIL orphan_valid got=%0b exp=0", o_valid_out); end
    cyc(9'h000, 0, 1);
  endtask

  task automatic test_reset_mid_packet();
    cyc(HEAD, 1, 1); cyc(B1, 1, 1);
    rst_n = 1'b0; i_valid_in = 1'b0;
    #1;
    total++; if (o_valid_out !== 1'b0 || o_packet_out !== 36'h0 || o_error !== 1'b0) begin bad++; $display("FAIL rst_mid_out got=%0b/%h/%0b exp=0/0/0", o_valid_out, o_packet_out, o_error); end
    total++; if (o_err_count !== 8'h00 || i_ready_out !== 1'b1) begin bad++; $display("FAIL rst_mid_cnt got=%h/%0b exp=00/1", o_err_count, i_ready_out); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cyc(HEAD, 1, 1); cyc(B1, 1, 1); cyc(B2, 1, 1); cyc(TAIL, 1, 1);
    total++; if (o_valid_out !== 1'b1 || o_packet_out !== PKT) begin bad++; $display("FAIL rst_mid_pkt got=%0b/%h exp=1/%h", o_valid_out, o_packet_out, PKT); end
    total++; if (o_err_count !== 8'h00) begin bad++; $display("FAIL rst_mid_errcnt got=%h exp=00", o_err_count); end
    idle_consume();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_stall();
    test_early_head();
    test_bubbles_orphans();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
